// File: rtl/cpu_pkg.sv
// Shared types and opcode constants for the LEGv8 fetch unit and its decoder.
// Opcodes are full-width words compared under their field masks.
package cpu_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] OP_HALT   = 32'hFFE0_0000;
  localparam logic [INST_W-1:0] MASK_HALT = 32'hFFE0_0000;
  localparam logic [INST_W-1:0] OP_B      = 32'h1400_0000;
  localparam logic [INST_W-1:0] MASK_B    = 32'hFC00_0000;
  localparam logic [INST_W-1:0] OP_CBZ    = 32'hB400_0000;
  localparam logic [INST_W-1:0] OP_CBNZ   = 32'hB500_0000;
  localparam logic [INST_W-1:0] MASK_CB   = 32'hFF00_0000;

  typedef enum logic [2:0] {
    ST_REQ      = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_BR  = 3'd3,
    ST_HALT     = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    CLS_SEQ  = 2'd0,
    CLS_B    = 2'd1,
    CLS_CB   = 2'd2,
    CLS_HALT = 2'd3
  } inst_class_e;

  function automatic inst_class_e classify(input logic [INST_W-1:0] inst);
    if ((inst & MASK_HALT) == OP_HALT) begin
      return CLS_HALT;
    end else if ((inst & MASK_B) == OP_B) begin
      return CLS_B;
    end else if (((inst & MASK_CB) == OP_CBZ) || ((inst & MASK_CB) == OP_CBNZ)) begin
      return CLS_CB;
    end else begin
      return CLS_SEQ;
    end
  endfunction

endpackage

// File: rtl/cpu_fetch_if.sv
// Fetch-side bus bundle: instruction memory request/response, decode
// valid/ready handoff, and the branch resolution return path from execute.
interface cpu_fetch_if #(
  parameter int PC_W = 64
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_inst;
  logic [PC_W-1:0] dec_pc;
  logic            br_valid;
  logic            br_taken;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_inst, dec_pc,
    input  imem_valid, imem_rdata, dec_ready, br_valid, br_taken
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_inst, dec_pc,
    output imem_valid, imem_rdata, dec_ready, br_valid, br_taken
  );

endinterface

// File: rtl/cpu_fetch_nextpc.sv
// Next-PC selection: sequential, B target, or CBZ/CBNZ taken/not-taken target.
// All adds wrap modulo 2^PC_W; offsets are word offsets sign-extended first.
module cpu_fetch_nextpc
  import cpu_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] inst,
  input  inst_class_e       cls,
  input  logic              br_taken,
  output logic [PC_W-1:0]   next_pc
);

  localparam logic [PC_W-1:0] PC_STEP = {{(PC_W-3){1'b0}}, 3'b100};

  logic [PC_W-1:0] off_b_s;
  logic [PC_W-1:0] off_cb_s;
  logic [PC_W-1:0] seq_pc_s;
  logic            unused_inst_bits;

  assign off_b_s  = {{(PC_W-28){inst[25]}}, inst[25:0], 2'b00};
  assign off_cb_s = {{(PC_W-21){inst[23]}}, inst[23:5], 2'b00};
  assign seq_pc_s = pc + PC_STEP;
  assign unused_inst_bits = ^{inst[31:26], inst[4:0]};

  // Target mux keyed by the class of the word being retired.
  always_comb begin
    next_pc = seq_pc_s;
    case (cls)
      CLS_B: begin
        next_pc = pc + off_b_s;
      end
      CLS_CB: begin
        if (br_taken) begin
          next_pc = pc + off_cb_s;
        end else begin
          next_pc = seq_pc_s;
        end
      end
      default: begin
        next_pc = seq_pc_s;
      end
    endcase
  end

endmodule

// File: rtl/cpu_fetch.sv
// LEGv8 instruction fetch/sequencing unit: one outstanding fetch, local B
// resolution, stall on CBZ/CBNZ, terminal HALT. CPU_FETCH_CNT_EN adds inst_count.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic        clk,
  input  logic        rst,
  cpu_fetch_if.master bus,
  output logic        halted
`ifdef CPU_FETCH_CNT_EN
  ,
  output logic [31:0] inst_count
`endif
);

  fetch_state_e      state_r;
  fetch_state_e      state_next_s;
  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   next_pc_s;
  logic [INST_W-1:0] inst_r;
  logic              req_r;
  logic              dec_valid_r;
  logic              halted_r;
  logic              dec_fire_s;
  logic              pc_load_s;
  logic              inst_load_s;
  inst_class_e       cls_s;

  assign dec_fire_s = dec_valid_r && bus.dec_ready;
  assign cls_s      = classify(inst_r);

  cpu_fetch_nextpc #(
    .PC_W(PC_W)
  ) u_nextpc (
    .pc      (pc_r),
    .inst    (inst_r),
    .cls     (cls_s),
    .br_taken(bus.br_taken),
    .next_pc (next_pc_s)
  );

  // Next-state and register-load decisions.
  always_comb begin
    state_next_s = state_r;
    pc_load_s    = 1'b0;
    inst_load_s  = 1'b0;
    case (state_r)
      ST_REQ: begin
        state_next_s = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        if (bus.imem_valid) begin
          inst_load_s  = 1'b1;
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_WAIT_MEM;
        end
      end
      ST_ISSUE: begin
        if (dec_fire_s) begin
          case (cls_s)
            CLS_HALT: state_next_s = ST_HALT;
            CLS_CB:   state_next_s = ST_WAIT_BR;
            default: begin
              pc_load_s    = 1'b1;
              state_next_s = ST_REQ;
            end
          endcase
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_WAIT_BR: begin
        if (bus.br_valid) begin
          pc_load_s    = 1'b1;
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_WAIT_BR;
        end
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_REQ;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_REQ;
    end else begin
      state_r <= state_next_s;
    end
  end

  // PC, instruction register and Moore outputs. The request strobe is the
  // registered image of the REQ state, so it is high for the one cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      inst_r      <= {INST_W{1'b0}};
      req_r       <= 1'b0;
      dec_valid_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      if (pc_load_s) begin
        pc_r <= next_pc_s;
      end
      if (inst_load_s) begin
        inst_r <= bus.imem_rdata;
      end
      req_r       <= (state_r == ST_REQ);
      dec_valid_r <= (state_next_s == ST_ISSUE);
      halted_r    <= (state_next_s == ST_HALT);
    end
  end

  assign bus.imem_req  = req_r;
  assign bus.imem_addr = pc_r;
  assign bus.dec_valid = dec_valid_r;
  assign bus.dec_inst  = inst_r;
  assign bus.dec_pc    = pc_r;
  assign halted        = halted_r;

`ifdef CPU_FETCH_CNT_EN
  logic [31:0] count_r;

  // Issued-instruction counter, HALT word included; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 32'd0;
    end else if (dec_fire_s) begin
      count_r <= count_r + 32'd1;
    end
  end

  assign inst_count = count_r;
`endif

endmodule

// File: tb/tb_cpu_fetch.sv
// Scoreboard bench for cpu_fetch: expected fetch addresses and issued words
// are queued as each program is loaded and popped as the DUT produces them.
module tb_cpu_fetch;

  localparam int PC_W = 64;
  localparam logic [31:0] W_ADD0 = 32'h8B02_0020;
  localparam logic [31:0] W_ADD1 = 32'h8B03_0041;
  localparam logic [31:0] W_ADD2 = 32'h8B04_0062;
  localparam logic [31:0] W_HALT = 32'hFFE0_0000;
  localparam logic [31:0] W_CBZ2 = 32'hB400_0040;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic halted;
`ifdef CPU_FETCH_CNT_EN
  logic [31:0] inst_count;
`endif

  cpu_fetch_if #(.PC_W(PC_W)) bus ();

  cpu_fetch #(
    .PC_W    (PC_W),
    .RESET_PC(64'h0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .halted(halted)
`ifdef CPU_FETCH_CNT_EN
    ,
    .inst_count(inst_count)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [63:0]];
  exp_t        issue_q[$];
  logic [63:0] fetch_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Advance one cycle; the memory answers a request in the same cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.imem_req) begin
      bus.imem_valid = 1'b1;
      bus.imem_rdata = mem.exists(bus.imem_addr) ? mem[bus.imem_addr] : W_ADD0;
    end else begin
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.dec_ready  = 1'b1;
    bus.br_valid   = 1'b0;
    bus.br_taken   = 1'b0;
    mem.delete();
    issue_q.delete();
    fetch_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_req(output bit ok, output logic [63:0] addr);
    ok   = 1'b0;
    addr = 64'h0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req) begin
        ok   = 1'b1;
        addr = bus.imem_addr;
        return;
      end
      tick();
    end
  endtask

  // Waits for dec_valid with dec_ready already high, then lets the handshake edge pass.
  task automatic wait_issue(output bit ok, output logic [63:0] pc, output logic [31:0] inst);
    ok   = 1'b0;
    pc   = 64'h0;
    inst = 32'h0;
    for (int i = 0; i < 20; i++) begin
      if (bus.dec_valid) begin
        ok   = 1'b1;
        pc   = bus.dec_pc;
        inst = bus.dec_inst;
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic load_cbz_prog();
    for (int i = 0; i < 4; i++) begin
      mem[64'(4 * i)] = W_ADD1;
      fetch_q.push_back(64'(4 * i));
      issue_q.push_back('{pc: 64'(4 * i), inst: W_ADD1});
    end
    mem[64'h10] = W_CBZ2;
    fetch_q.push_back(64'h10);
    issue_q.push_back('{pc: 64'h10, inst: W_CBZ2});
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.dec_ready  = 1'b0;
    bus.br_valid   = 1'b0;
    bus.br_taken   = 1'b0;
    #2;
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); end
    n_cmp++;
    if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_dec_valid: got %b want 0", bus.dec_valid); end
    n_cmp++;
    if (bus.dec_inst !== 32'h0) begin n_err++; $display("FAIL reset_dec_inst: got %h want 0", bus.dec_inst); end
    n_cmp++;
    if (bus.dec_pc !== 64'h0) begin n_err++; $display("FAIL reset_dec_pc: got %h want 0", bus.dec_pc); end
    n_cmp++;
    if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
`ifdef CPU_FETCH_CNT_EN
    n_cmp++;
    if (inst_count !== 32'd0) begin n_err++; $display("FAIL reset_inst_count: got %0d want 0", inst_count); end
`endif
  endtask

  task automatic test_sequential();
    bit ok; logic [63:0] a, p, e; logic [31:0] w; exp_t x;
    do_reset();
    mem[64'h0] = W_ADD0; mem[64'h4] = W_ADD1;
    fetch_q.push_back(64'h0); fetch_q.push_back(64'h4);
    issue_q.push_back('{pc: 64'h0, inst: W_ADD0});
    issue_q.push_back('{pc: 64'h4, inst: W_ADD1});
    tick();
    n_cmp++;
    if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
    while (fetch_q.size() > 0) begin
      wait_req(ok, a); e = fetch_q.pop_front(); n_cmp++;
      if (!ok || a !== e) begin n_err++; $display("FAIL seq_fetch: got %h (seen %0d) want %h", a, ok, e); end
      wait_issue(ok, p, w); x = issue_q.pop_front(); n_cmp++;
      if (!ok || p !== x.pc || w !== x.inst) begin
        n_err++; $display("FAIL seq_issue: got pc %h inst %h (seen %0d) want pc %h inst %h", p, w, ok, x.pc, x.inst);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok; logic [63:0] a, e; exp_t x; int bad;
    do_reset();
    mem[64'h0] = W_ADD2; mem[64'h4] = W_ADD1;
    fetch_q.push_back(64'h0); fetch_q.push_back(64'h4);
    issue_q.push_back('{pc: 64'h0, inst: W_ADD2});
    bus.dec_ready = 1'b0;
    wait_req(ok, a); e = fetch_q.pop_front(); n_cmp++;
    if (!ok || a !== e) begin n_err++; $display("FAIL bp_fetch0: got %h (seen %0d) want %h", a, ok, e); end
    for (int i = 0; i < 10 && !bus.dec_valid; i++) tick();
    n_cmp++;
    if (bus.dec_valid !== 1'b1) begin n_err++; $display("FAIL bp_offer: got dec_valid %b want 1", bus.dec_valid); end
    x = issue_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      tick();
      bad = (bus.dec_valid !== 1'b1) || (bus.dec_inst !== x.inst) || (bus.dec_pc !== x.pc) || (bus.imem_req !== 1'b0);
      n_cmp++;
      if (bad != 0) begin
        n_err++; $display("FAIL bp_hold: cycle %0d got valid %b inst %h pc %h req %b want 1 %h %h 0",
                          i, bus.dec_valid, bus.dec_inst, bus.dec_pc, bus.imem_req, x.inst, x.pc);
      end
    end
    bus.dec_ready = 1'b1;
    tick();
    wait_req(ok, a); e = fetch_q.pop_front(); n_cmp++;
    if (!ok || a !== e) begin n_err++; $display("FAIL bp_fetch1: got %h (seen %0d) want %h", a, ok, e); end
  endtask

  task automatic test_branch_b();
    bit ok; logic [63:0] a, p, e; logic [31:0] w, bw; exp_t x;
    for (int v = 0; v < 2; v++) begin
      do_reset();
      bw = (v == 0) ? 32'h1400_0003 : 32'h17FF_FFFF;
      mem[64'h0] = W_ADD0; mem[64'h4] = W_ADD1; mem[64'h8] = bw;
      fetch_q.push_back(64'h0); fetch_q.push_back(64'h4); fetch_q.push_back(64'h8);
      fetch_q.push_back((v == 0) ? 64'h14 : 64'h4);
      issue_q.push_back('{pc: 64'h0, inst: W_ADD0});
      issue_q.push_back('{pc: 64'h4, inst: W_ADD1});
      issue_q.push_back('{pc: 64'h8, inst: bw});
      while (fetch_q.size() > 0) begin
        wait_req(ok, a); e = fetch_q.pop_front(); n_cmp++;
        if (!ok || a !== e) begin n_err++; $display("FAIL b_fetch v%0d: got %h (seen %0d) want %h", v, a, ok, e); end
        if (issue_q.size() > 0) begin
          wait_issue(ok, p, w); x = issue_q.pop_front(); n_cmp++;
          if (!ok || p !== x.pc || w !== x.inst) begin
            n_err++; $display("FAIL b_issue v%0d: got pc %h inst %h want pc %h inst %h", v, p, w, x.pc, x.inst);
          end
        end
      end
    end
  endtask

  task automatic test_cond_branch();
    bit ok; logic [63:0] a, p, e; logic [31:0] w; exp_t x; int reqs;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      load_cbz_prog();
      while (fetch_q.size() > 0) begin
        wait_req(ok, a); e = fetch_q.pop_front(); n_cmp++;
        if (!ok || a !== e) begin n_err++; $display("FAIL cb_fetch t%0d: got %h want %h", t, a, e); end
        wait_issue(ok, p, w); x = issue_q.pop_front(); n_cmp++;
        if (!ok || p !== x.pc || w !== x.inst) begin
          n_err++; $display("FAIL cb_issue t%0d: got pc %h inst %h want pc %h inst %h", t, p, w, x.pc, x.inst);
        end
      end
      fetch_q.push_back((t == 1) ? 64'h18 : 64'h14);
      reqs = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        reqs += int'(bus.imem_req) + int'(bus.dec_valid);
      end
      n_cmp++;
      if (reqs != 0) begin n_err++; $display("FAIL cb_stall t%0d: got %0d req/valid cycles want 0", t, reqs); end
      bus.br_taken = (t == 1);
      bus.br_valid = 1'b1;
      tick();
      bus.br_valid = 1'b0;
      bus.br_taken = 1'b0;
      wait_req(ok, a); e = fetch_q.pop_front(); n_cmp++;
      if (!ok || a !== e) begin n_err++; $display("FAIL cb_target t%0d: got %h (seen %0d) want %h", t, a, ok, e); end
    end
  endtask

  task automatic test_halt();
    bit ok; logic [63:0] a, p, e; logic [31:0] w; exp_t x; int extra;
    do_reset();
    mem[64'h0] = W_ADD0; mem[64'h4] = W_ADD1; mem[64'h8] = W_ADD2; mem[64'hC] = W_HALT;
    for (int i = 0; i < 4; i++) begin
      fetch_q.push_back(64'(4 * i));
      issue_q.push_back('{pc: 64'(4 * i), inst: mem[64'(4 * i)]});
    end
    while (fetch_q.size() > 0) begin
      wait_req(ok, a); e = fetch_q.pop_front(); n_cmp++;
      if (!ok || a !== e) begin n_err++; $display("FAIL halt_fetch: got %h want %h", a, e); end
      wait_issue(ok, p, w); x = issue_q.pop_front(); n_cmp++;
      if (!ok || p !== x.pc || w !== x.inst) begin
        n_err++; $display("FAIL halt_issue: got pc %h inst %h want pc %h inst %h", p, w, x.pc, x.inst);
      end
    end
    n_cmp++;
    if (halted !== 1'b1) begin n_err++; $display("FAIL halted_flag: got %b want 1", halted); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      extra += int'(bus.imem_req) + int'(bus.dec_valid);
    end
    n_cmp++;
    if (extra != 0) begin n_err++; $display("FAIL halt_quiet: got %0d req/valid cycles want 0", extra); end
`ifdef CPU_FETCH_CNT_EN
    n_cmp++;
    if (inst_count !== 32'd4) begin n_err++; $display("FAIL halt_count: got %0d want 4", inst_count); end
`endif
  endtask

  task automatic test_reset_in_wait_br();
    bit ok; logic [63:0] a, p, e; logic [31:0] w; exp_t x; int bad;
    do_reset();
    load_cbz_prog();
    while (fetch_q.size() > 0) begin
      wait_req(ok, a); e = fetch_q.pop_front();
      wait_issue(ok, p, w); x = issue_q.pop_front();
    end
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    bad = (bus.imem_req !== 1'b0) || (bus.dec_valid !== 1'b0) || (bus.dec_inst !== 32'h0) ||
          (bus.dec_pc !== 64'h0) || (halted !== 1'b0);
`ifdef CPU_FETCH_CNT_EN
    bad = bad | int'(inst_count !== 32'd0);
`endif
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL async_reset: got req %b valid %b inst %h pc %h halted %b want 0 0 0 0 0",
                        bus.imem_req, bus.dec_valid, bus.dec_inst, bus.dec_pc, halted);
    end
    bus.imem_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem[64'h0] = W_ADD2;
    fetch_q.push_back(64'h0);
    issue_q.push_back('{pc: 64'h0, inst: W_ADD2});
    wait_req(ok, a); e = fetch_q.pop_front(); n_cmp++;
    if (!ok || a !== e) begin n_err++; $display("FAIL restart_fetch: got %h (seen %0d) want %h", a, ok, e); end
    wait_issue(ok, p, w); x = issue_q.pop_front(); n_cmp++;
    if (!ok || p !== x.pc || w !== x.inst) begin
      n_err++; $display("FAIL restart_issue: got pc %h inst %h want pc %h inst %h", p, w, x.pc, x.inst);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_b();
    test_cond_branch();
    test_halt();
    test_reset_in_wait_br();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
